intc_arb: RTL and testbench

Interrupt priority arbiter for the J22 core. It collects up to `NSRC` peripheral interrupt lines plus NMI and compares their programmed priorities against the SR interrupt mask. It presents a single frozen request (`intreq`, vector, level) to the instruction decoder and sequences the `intack` handshake, including a hold-off window while SR.I is updated. It sits between the peripheral bus and `idec`, and is configured through a small register port.

---
 rtl/intc_arb_if.sv | 27 ++
 rtl/intc_arb.sv | 213 +++++++++++++++++++++
 tb/tb_intc_arb.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/intc_arb_if.sv
// Signal bundle between intc_arb and its neighbours: peripheral irq lines, the
// register port, SR.I and the idec request/acknowledge handshake.
interface intc_arb_if #(
    parameter int NSRC = 8
);
    logic [NSRC-1:0] irq;
    logic            nmi;
    logic [3:0]      imask;
    logic            cfg_we;
    logic [2:0]      cfg_addr;
    logic [15:0]     cfg_wdata;
    logic [15:0]     cfg_rdata;
    logic            intreq;
    logic [7:0]      int_vec;
    logic [3:0]      int_lvl;
    logic            intack;

    modport master (
        output irq, nmi, imask, cfg_we, cfg_addr, cfg_wdata, intack,
        input  cfg_rdata, intreq, int_vec, int_lvl
    );

    modport slave (
        input  irq, nmi, imask, cfg_we, cfg_addr, cfg_wdata, intack,
        output cfg_rdata, intreq, int_vec, int_lvl
    );
endinterface

// File: rtl/intc_arb.sv
// Interrupt priority arbiter for the J22 core: masks, arbitrates and presents one frozen
// request to idec. Define INTC_EDGE_EN to add per-source edge mode with pending bits.
//
// state  | meaning
// S_IDLE | waiting for any eligible source or pending NMI
// S_ARB  | latch winner index, vector and level; raise intreq
// S_REQ  | intreq held with frozen vector/level until intack
// S_HOLD | hold-off down-counter running, no new request raised
module intc_arb #(
    parameter int NSRC    = 8,
    parameter int HOLDOFF = 4
) (
    input  logic        clk,
    input  logic        rst,
    intc_arb_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_ARB, S_REQ, S_HOLD} state_t;

    state_t          state, state_next;
    logic [NSRC-1:0] irq_q;
    logic            nmi_q;
    logic            nmi_pend;
    logic [3:0]      pri [NSRC];
    logic [7:0]      vec [NSRC];
    logic [NSRC-1:0] act;
    logic [NSRC-1:0] elig;
    logic [15:0]     rdata_next;
    logic [3:0]      cnt;

    logic            arb_any;
    logic [2:0]      arb_idx;
    logic [3:0]      arb_pri;
    logic [7:0]      arb_vec;
    logic            any_elig;
    logic [7:0]      sel_vec;
    logic [3:0]      sel_lvl;

    logic            cap_nmi, win_nmi;
    logic [2:0]      cap_idx, win_idx;
    logic [7:0]      cap_vec, vec_r;
    logic [3:0]      cap_lvl, lvl_r;
    logic            intreq_r;
    logic            ack;

`ifdef INTC_EDGE_EN
    logic [NSRC-1:0] edge_mode;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] clr;

    always_comb begin
        clr = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (ack && !win_nmi && win_idx == 3'(i)) clr[i] = 1'b1;
        end
    end

    // A fresh edge in the acknowledge cycle survives the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~clr) | (bus.irq & ~irq_q & edge_mode);
        end
    end

    assign act = (edge_mode & pend) | (~edge_mode & irq_q);

    wire unused_cfg = ^bus.cfg_wdata[7:5];
`else
    assign act = irq_q;

    wire unused_cfg = ^{bus.cfg_wdata[7:4], win_idx};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSRC; i++) begin
                pri[i] <= '0;
                vec[i] <= '0;
            end
`ifdef INTC_EDGE_EN
            edge_mode <= '0;
`endif
            bus.cfg_rdata <= '0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (bus.cfg_we && bus.cfg_addr == 3'(i)) begin
                    pri[i] <= bus.cfg_wdata[3:0];
                    vec[i] <= bus.cfg_wdata[15:8];
`ifdef INTC_EDGE_EN
                    edge_mode[i] <= bus.cfg_wdata[4];
`endif
                end
            end
            bus.cfg_rdata <= rdata_next;
        end
    end

    always_comb begin
        rdata_next = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (bus.cfg_addr == 3'(i)) begin
                rdata_next[15:8] = vec[i];
                rdata_next[3:0]  = pri[i];
`ifdef INTC_EDGE_EN
                rdata_next[4]    = edge_mode[i];
`endif
            end
        end
    end

    // Vectors below 0x04 belong to reset entry points and disable the source.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            elig[i] = act[i] && (pri[i] != 4'd0) && (pri[i] > bus.imask) && (vec[i] >= 8'h04);
        end
    end

    // Ascending scan with strict compare keeps the lowest index on ties.
    always_comb begin
        arb_any = 1'b0;
        arb_idx = '0;
        arb_pri = '0;
        arb_vec = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (elig[i] && (!arb_any || pri[i] > arb_pri)) begin
                arb_any = 1'b1;
                arb_idx = 3'(i);
                arb_pri = pri[i];
                arb_vec = vec[i];
            end
        end
    end

    assign any_elig = nmi_pend || arb_any;
    assign sel_vec  = nmi_pend ? 8'h0B : arb_vec;
    assign sel_lvl  = nmi_pend ? 4'hF  : arb_pri;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        ack        = 1'b0;
        case (state)
            S_IDLE: if (any_elig) state_next = S_ARB;
            S_ARB:  state_next = S_REQ;
            S_REQ: begin
                if (bus.intack) begin
                    ack        = 1'b1;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: if (cnt == 4'd1) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // The IDLE snapshot backs up the ARB decision if eligibility vanishes in between.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q    <= '0;
            nmi_q    <= 1'b0;
            nmi_pend <= 1'b0;
            cnt      <= '0;
            cap_nmi  <= 1'b0;
            cap_idx  <= '0;
            cap_vec  <= '0;
            cap_lvl  <= '0;
            win_nmi  <= 1'b0;
            win_idx  <= '0;
            vec_r    <= '0;
            lvl_r    <= '0;
            intreq_r <= 1'b0;
        end else begin
            irq_q    <= bus.irq;
            nmi_q    <= bus.nmi;
            nmi_pend <= (nmi_pend & ~(ack & win_nmi)) | (bus.nmi & ~nmi_q);
            if (state == S_IDLE && any_elig) begin
                cap_nmi <= nmi_pend;
                cap_idx <= arb_idx;
                cap_vec <= sel_vec;
                cap_lvl <= sel_lvl;
            end
            if (state == S_ARB) begin
                intreq_r <= 1'b1;
                if (any_elig) begin
                    win_nmi <= nmi_pend;
                    win_idx <= arb_idx;
                    vec_r   <= sel_vec;
                    lvl_r   <= sel_lvl;
                end else begin
                    win_nmi <= cap_nmi;
                    win_idx <= cap_idx;
                    vec_r   <= cap_vec;
                    lvl_r   <= cap_lvl;
                end
            end
            if (ack) begin
                intreq_r <= 1'b0;
                cnt      <= 4'(HOLDOFF);
            end else if (state == S_HOLD) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign bus.intreq  = intreq_r;
    assign bus.int_vec = vec_r;
    assign bus.int_lvl = lvl_r;
endmodule

// File: tb/tb_intc_arb.sv
// Directed bench for intc_arb (NSRC=8, HOLDOFF=4); edge-mode cases run when
// INTC_EDGE_EN is defined.
module tb_intc_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    intc_arb_if #(.NSRC(8)) bus ();

    intc_arb #(.NSRC(8), .HOLDOFF(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_wr(input logic [2:0] a, input logic [15:0] d);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = a;
        bus.cfg_wdata = d;
        step(1);
        bus.cfg_we    = 1'b0;
    endtask

    task automatic wait_req(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            if (bus.intreq) break;
            step(1);
        end
        chk(tag, 32'(bus.intreq), 32'd1);
    endtask

    task automatic ack();
        bus.intack = 1'b1;
        step(1);
        bus.intack = 1'b0;
    endtask

    initial begin
        bus.irq = '0; bus.nmi = 1'b0; bus.imask = 4'd0; bus.intack = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_addr = 3'd0; bus.cfg_wdata = 16'h0;
        step(2);
        rst = 1'b0;
        step(1);
        chk("rst_intreq", 32'(bus.intreq), 32'd0);
        chk("rst_vec", 32'(bus.int_vec), 32'h0);
        chk("rst_lvl", 32'(bus.int_lvl), 32'h0);
        chk("rst_rdata", 32'(bus.cfg_rdata), 32'h0);

        // readback: bit 4 only survives in edge builds
        cfg_wr(3'd2, 16'h4005);
        cfg_wr(3'd7, 16'h2013);
        bus.cfg_addr = 3'd2;
        step(1);
        chk("rd_src2", 32'(bus.cfg_rdata), 32'h4005);
        bus.cfg_addr = 3'd7;
        step(1);
`ifdef INTC_EDGE_EN
        chk("rd_src7", 32'(bus.cfg_rdata), 32'h2013);
`else
        chk("rd_src7", 32'(bus.cfg_rdata), 32'h2003);
`endif
        bus.cfg_addr = 3'd3;
        step(1);
        chk("rd_src3", 32'(bus.cfg_rdata), 32'h0);

        // single source latency and hold-off
        bus.imask = 4'd3;
        bus.irq[2] = 1'b1;
        step(1);
        chk("t1_lat0", 32'(bus.intreq), 32'd0);
        step(1);
        chk("t1_lat1", 32'(bus.intreq), 32'd0);
        step(1);
        chk("t1_req", 32'(bus.intreq), 32'd1);
        chk("t1_vec", 32'(bus.int_vec), 32'h40);
        chk("t1_lvl", 32'(bus.int_lvl), 32'h5);
        ack();
        chk("t1_drop", 32'(bus.intreq), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            step(1);
            chk("t1_hold", 32'(bus.intreq), 32'd0);
        end
        step(1);
        chk("t1_rereq", 32'(bus.intreq), 32'd1);
        bus.irq[2] = 1'b0;
        ack();
        step(8);
        chk("t1_idle", 32'(bus.intreq), 32'd0);

        // masking and reserved vectors
        cfg_wr(3'd0, 16'h1003);
        bus.irq[0] = 1'b1;
        step(6);
        chk("t2_masked", 32'(bus.intreq), 32'd0);
        bus.imask = 4'd2;
        step(1);
        chk("t2_arb", 32'(bus.intreq), 32'd0);
        step(1);
        chk("t2_req", 32'(bus.intreq), 32'd1);
        chk("t2_lvl", 32'(bus.int_lvl), 32'h3);
        chk("t2_vec", 32'(bus.int_vec), 32'h10);
        bus.irq[0] = 1'b0;
        ack();
        step(6);
        bus.imask = 4'd0;
        cfg_wr(3'd1, 16'h0209);
        bus.irq[1] = 1'b1;
        step(8);
        chk("t2_resvec", 32'(bus.intreq), 32'd0);
        cfg_wr(3'd1, 16'h0409);
        wait_req("t2_vec04_req", 10);
        chk("t2_vec04", 32'(bus.int_vec), 32'h04);
        bus.irq[1] = 1'b0;
        ack();
        step(8);

        // priority then tie on lowest index
        cfg_wr(3'd1, 16'h2107);
        cfg_wr(3'd4, 16'h2407);
        cfg_wr(3'd3, 16'h2309);
        bus.irq[1] = 1'b1; bus.irq[3] = 1'b1; bus.irq[4] = 1'b1;
        wait_req("t3_req_a", 10);
        chk("t3_vec_a", 32'(bus.int_vec), 32'h23);
        chk("t3_lvl_a", 32'(bus.int_lvl), 32'h9);
        bus.irq[3] = 1'b0;
        ack();
        wait_req("t3_req_b", 12);
        chk("t3_vec_b", 32'(bus.int_vec), 32'h21);
        chk("t3_lvl_b", 32'(bus.int_lvl), 32'h7);
        bus.irq[1] = 1'b0;
        ack();
        wait_req("t3_req_c", 12);
        chk("t3_vec_c", 32'(bus.int_vec), 32'h24);
        bus.irq[4] = 1'b0;
        ack();
        step(8);

        // NMI beats a simultaneous pri-15 source
        cfg_wr(3'd0, 16'h100F);
        bus.irq[0] = 1'b1;
        bus.nmi = 1'b1;
        step(3);
        chk("t4_nmi_req", 32'(bus.intreq), 32'd1);
        chk("t4_nmi_vec", 32'(bus.int_vec), 32'h0B);
        chk("t4_nmi_lvl", 32'(bus.int_lvl), 32'hF);
        bus.nmi = 1'b0;
        ack();
        step(5);
        chk("t4_hold", 32'(bus.intreq), 32'd0);
        step(1);
        chk("t4_src_req", 32'(bus.intreq), 32'd1);
        chk("t4_src_vec", 32'(bus.int_vec), 32'h10);
        chk("t4_src_lvl", 32'(bus.int_lvl), 32'hF);
        bus.irq[0] = 1'b0;
        ack();
        step(8);

        // frozen request, NMI deferred past HOLD
        bus.imask = 4'd3;
        bus.irq[2] = 1'b1;
        wait_req("t5_req", 10);
        chk("t5_vec0", 32'(bus.int_vec), 32'h40);
        bus.irq[2] = 1'b0;
        bus.imask = 4'd15;
        bus.nmi = 1'b1;
        cfg_wr(3'd2, 16'h5501);
        bus.nmi = 1'b0;
        step(2);
        chk("t5_frz_req", 32'(bus.intreq), 32'd1);
        chk("t5_frz_vec", 32'(bus.int_vec), 32'h40);
        chk("t5_frz_lvl", 32'(bus.int_lvl), 32'h5);
        ack();
        chk("t5_drop", 32'(bus.intreq), 32'd0);
        step(5);
        chk("t5_nmi_hold", 32'(bus.intreq), 32'd0);
        step(1);
        chk("t5_nmi_req", 32'(bus.intreq), 32'd1);
        chk("t5_nmi_vec", 32'(bus.int_vec), 32'h0B);
        ack();
        step(6);

        // asynchronous reset in REQ
        bus.imask = 4'd0;
        bus.irq[2] = 1'b1;
        wait_req("t6_req", 10);
        chk("t6_vec", 32'(bus.int_vec), 32'h55);
        rst = 1'b1;
        #1;
        chk("t6_rst_req", 32'(bus.intreq), 32'd0);
        chk("t6_rst_vec", 32'(bus.int_vec), 32'h0);
        chk("t6_rst_lvl", 32'(bus.int_lvl), 32'h0);
        step(1);
        rst = 1'b0;
        step(6);
        chk("t6_cfg_gone", 32'(bus.intreq), 32'd0);
        bus.irq[2] = 1'b0;

`ifdef INTC_EDGE_EN
        // edge mode: short pulse, then re-arm coincident with intack
        cfg_wr(3'd5, 16'h3516);
        bus.irq[5] = 1'b1;
        step(1);
        bus.irq[5] = 1'b0;
        wait_req("t7_req_a", 10);
        chk("t7_vec_a", 32'(bus.int_vec), 32'h35);
        chk("t7_lvl_a", 32'(bus.int_lvl), 32'h6);
        bus.irq[5] = 1'b1;
        ack();
        bus.irq[5] = 1'b0;
        chk("t7_drop", 32'(bus.intreq), 32'd0);
        wait_req("t7_req_b", 12);
        chk("t7_vec_b", 32'(bus.int_vec), 32'h35);
        ack();
        step(10);
        chk("t7_no_third", 32'(bus.intreq), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
